shift_cmd_seq: RTL
==================

Name: shift_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the 8-bit loadable shifter's combinational next-state logic and result register.
- Accepts queued shift commands over a valid/ready interface and drives the shifter's op, shamt and d_in each cycle.
- Shifts larger than 3 are split into steps of at most 3.
- Reports each command's final register value on a one-cycle response strobe.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals (count != DEPTH)
- cmd_op  in  3  000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR; 101–111 illegal
- cmd_amt  in  3  total shift amount 0–7; ignored for NOP/LOAD
- cmd_data  in  8  load value; ignored except for LOAD
- op  out  3  opcode to shifter logic
- shamt  out  2  per-step shift amount to shifter logic
- d_in  out  8  load data to shifter logic
- d_out  in  8  current shifter register value (feedback)
- rsp_valid  out  1  one-cycle pulse: command complete
- rsp_data  out  8  d_out sampled while rsp_valid=1
- rsp_err  out  1  qualifies rsp_valid; command had illegal op
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied; state IDLE; remaining-count register = 0.
  - op=000, shamt=00, d_in=0x00, rsp_valid=0, rsp_err=0, cmd_ready=1, busy=0.
  - Reset mid-command discards the in-flight command and all queued commands, with no response.
- FIFO:
  - A push occurs on an edge where cmd_valid & cmd_ready.
  - A pop occurs when the FSM loads the head entry.
  - cmd_ready depends only on count, never on same-cycle pop.
  - Push and pop on the same edge leave count unchanged.
  - A push into an empty FIFO is not visible to the FSM until the next edge; there is no bypass.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Outputs: op=NOP, shamt=0, d_in=0.
  - If FIFO non-empty at the edge: pop head into working regs (wop, wrem=cmd_amt, wdata), go to ISSUE.
  - Illegal op: wop is forced to NOP and the err flag is set.
- ISSUE:
  - Outputs: op=wop, d_in=wdata for LOAD (else 0x00).
  - Shift ops: shamt = min(wrem,3); NOP/LOAD: shamt=0.
  - At the edge, wrem -= shamt.
  - Stay in ISSUE while the post-subtract wrem != 0; otherwise go to DONE.
  - NOP, LOAD, illegal and amt=0 commands take exactly one ISSUE cycle; amt=0 issues shamt=0.
  - Step decomposition: amt 7 → 3,3,1; 5 → 3,2; 4 → 3,1; 3 → 3.
  - ISSUE cycles = max(1, ceil(amt/3)).
- DONE:
  - Outputs: op=NOP; rsp_valid=1; rsp_data=d_out (already holds the result); rsp_err=err flag.
  - At the edge: if FIFO non-empty, pop into working regs and go to ISSUE (back-to-back); else go to IDLE.
- Latency: a command pushed at edge e0 into an idle, empty sequencer enters ISSUE at e1; rsp_valid is high in the cycle after the last ISSUE cycle. LOAD: rsp_valid in cycle [e2,e3).
- Throughput: one command per (ISSUE cycles + 1) cycles when queued.
- There is no response backpressure; the consumer must take rsp_valid pulses.
- Outputs op/shamt/d_in are decoded from registered state only; they have no combinational path from cmd_*.

Test Plan:
- Push LOAD 0xB5, then LSL amt 5 → LOAD response rsp_data=0xB5; LSL issues shamt 3,2; response rsp_data=0xA0, rsp_err=0.
- LOAD 0x80, ASR amt 7 → shamt sequence 3,3,1; response rsp_data=0xFF; 3 ISSUE cycles then 1 DONE cycle.
- LOAD 0xF0, LSR amt 4, LSR amt 0 → responses 0xF0, 0x0F, 0x0F; amt 0 issues one cycle of shamt=0.
- Hold cmd_valid with 6 back-to-back LSL amt 7 → cmd_ready drops once count reaches 4, rises on the first pop; all 6 responses arrive in order, none lost or duplicated.
- Push op 3'b110 → one ISSUE cycle with op=NOP; response rsp_err=1, rsp_data unchanged register value.
- Assert reset_n=0 during the second ISSUE step of ASR amt 7 with 2 queued → immediately op=NOP, busy=0, cmd_ready=1; no rsp_valid afterwards.

Source files
------------

// File: rtl/shift_cmd_seq_if.sv
// Bundles the shift sequencer's command, shifter-drive and response signals.
// The master side is the environment (command source plus shifter); the slave side is the sequencer.
interface shift_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_amt;
  logic [7:0] cmd_data;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, d_out,
    input  cmd_ready, op, shamt, d_in, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, d_out,
    output cmd_ready, op, shamt, d_in, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/shift_cmd_seq.sv
// Command sequencer for the 8-bit loadable shifter: queues commands, splits
// long shifts into steps of at most 3 and reports each result.
module shift_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  shift_cmd_seq_if.slave bus,
  output logic           busy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
  localparam logic [2:0]  OP_NOP  = 3'd0;
  localparam logic [2:0]  OP_LOAD = 3'd1;
  localparam logic [2:0]  OP_LSL  = 3'd2;
  localparam logic [2:0]  OP_LSR  = 3'd3;
  localparam logic [2:0]  OP_ASR  = 3'd4;
  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  ISSUE   = 2'd1;
  localparam logic [1:0]  DONE    = 2'd2;

  logic [13:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  logic [1:0]    state;
  logic [2:0]    wop;
  logic [2:0]    wrem;
  logic [7:0]    wdata;
  logic          werr;

  logic [2:0]    head_op;
  logic [2:0]    head_amt;
  logic [7:0]    head_data;
  logic          head_bad;
  logic          head_shift;
  logic          is_shift;
  logic [1:0]    step;
  logic [2:0]    rem_next;

  assign bus.cmd_ready = (count != FULL);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign pop           = ((state == IDLE) || (state == DONE)) && (count != '0);

  assign {head_op, head_amt, head_data} = mem[rd_ptr];
  assign head_bad   = (head_op > OP_ASR);
  assign head_shift = (head_op == OP_LSL) || (head_op == OP_LSR) || (head_op == OP_ASR);

  assign is_shift = (wop == OP_LSL) || (wop == OP_LSR) || (wop == OP_ASR);
  assign step     = !is_shift ? 2'd0 : ((wrem > 3'd3) ? 2'd3 : wrem[1:0]);
  assign rem_next = wrem - {1'b0, step};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_op, bus.cmd_amt, bus.cmd_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Non-shift commands get a zero remaining count so they finish after one ISSUE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wop   <= OP_NOP;
      wrem  <= 3'd0;
      wdata <= 8'h00;
      werr  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (pop) begin
            wop   <= head_bad ? OP_NOP : head_op;
            wrem  <= head_shift ? head_amt : 3'd0;
            wdata <= head_data;
            werr  <= head_bad;
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          wrem <= rem_next;
          if (rem_next == 3'd0) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.op    = OP_NOP;
    bus.shamt = 2'd0;
    bus.d_in  = 8'h00;
    if (state == ISSUE) begin
      bus.op    = wop;
      bus.shamt = step;
      if (wop == OP_LOAD) begin
        bus.d_in = wdata;
      end
    end
  end

  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = bus.d_out;
  assign bus.rsp_err   = (state == DONE) & werr;
  assign busy          = (state != IDLE) || (count != '0);

endmodule
